cfg_bitstream_loader: RTL and testbench

- Upstream feeder of the per-tile serial configuration chain.
- Accepts configuration words from the host over a valid/ready handshake and holds the tile chain in reset, then releases it.
- After release, emits a `num_of_tiles`-cycle idle preamble, then an unbroken MSB-first bitstream of `num_of_tiles*mem_cycles` bits with `data_valid` high.
- The stream is gap-free so that each tile's clock-count capture window lines up bit-exactly; an underrun aborts the load.

---
 rtl/cfg_bitstream_loader.sv | 196 +++++++++++++++++++
 tb/tb_cfg_bitstream_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_bitstream_loader.sv
// Feeds the tile configuration chain: reset, idle preamble, then a gap-free MSB-first bitstream.
// States: IDLE wait start | CHAIN_RST chain held | PREAMBLE idle bits | STREAM shifting | DONE pulse | ERROR underrun
module cfg_bitstream_loader #(
  parameter int num_of_tiles = 9,
  parameter int mem_cycles   = 4096,
  parameter int word_width   = 32,
  parameter int rst_cycles   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [word_width-1:0] word_in_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  chain_rst_o,
  output logic                  data_out_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int TOTAL  = num_of_tiles * mem_cycles;
  localparam int NWORDS = TOTAL / word_width;
  localparam int BW     = $clog2(TOTAL + 1);
  localparam int NWW    = $clog2(NWORDS + 1);
  localparam int WBW    = $clog2(word_width + 1);
  localparam int CMAX   = (rst_cycles > num_of_tiles) ? rst_cycles : num_of_tiles;
  localparam int CW     = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHAIN_RST, S_PREAMBLE, S_STREAM, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [NWW-1:0]        word_cnt_q, word_cnt_d;
  logic [WBW-1:0]        wbit_q, wbit_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [word_width-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  word_ready_q, word_ready_d;
  logic                  chain_rst_q, chain_rst_d;
  logic                  data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  xfer, avail, launch;
  logic [word_width-1:0] next_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    wbit_d     = wbit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    data_out_d = 1'b0;
    launch     = 1'b0;

    // A word handshaken on the reload edge bypasses the buffer so the stream never stalls.
    xfer      = word_valid_i & word_ready_q;
    avail     = buf_full_q | xfer;
    next_word = buf_full_q ? buf_q : word_in_i;

    if (xfer) begin
      buf_d      = word_in_i;
      buf_full_d = 1'b1;
      word_cnt_d = word_cnt_q + NWW'(1);
    end

    case (state_q)
      S_IDLE: launch = start_i;
      S_CHAIN_RST: begin
        if (cnt_q == '0) begin
          state_d = S_PREAMBLE;
          cnt_d   = CW'(num_of_tiles - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PREAMBLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (avail) begin
          state_d    = S_STREAM;
          data_out_d = next_word[word_width-1];
          shift_d    = next_word << 1;
          wbit_d     = WBW'(1);
          bit_cnt_d  = BW'(1);
          buf_full_d = 1'b0;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_STREAM: begin
        if (bit_cnt_q == BW'(TOTAL)) begin
          state_d = S_DONE;
        end else if (wbit_q == WBW'(word_width)) begin
          if (avail) begin
            data_out_d = next_word[word_width-1];
            shift_d    = next_word << 1;
            wbit_d     = WBW'(1);
            bit_cnt_d  = bit_cnt_q + BW'(1);
            buf_full_d = 1'b0;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          data_out_d = shift_q[word_width-1];
          shift_d    = shift_q << 1;
          wbit_d     = wbit_q + WBW'(1);
          bit_cnt_d  = bit_cnt_q + BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        launch  = start_i;
      end
      S_ERROR: begin
        buf_full_d = 1'b0;
        launch     = start_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d    = S_CHAIN_RST;
      cnt_d      = CW'(rst_cycles - 1);
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      wbit_d     = '0;
      buf_full_d = 1'b0;
    end
    if (state_d == S_ERROR) buf_full_d = 1'b0;

    chain_rst_d  = (state_d == S_IDLE) || (state_d == S_CHAIN_RST) ||
                   (state_d == S_DONE) || (state_d == S_ERROR);
    data_valid_d = (state_d == S_STREAM);
    busy_d       = (state_d == S_CHAIN_RST) || (state_d == S_PREAMBLE) || (state_d == S_STREAM);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    word_ready_d = ((state_d == S_PREAMBLE) || (state_d == S_STREAM)) &&
                   !buf_full_d && (word_cnt_d < NWW'(NWORDS));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      wbit_q       <= '0;
      shift_q      <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      word_ready_q <= 1'b0;
      chain_rst_q  <= 1'b1;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      wbit_q       <= wbit_d;
      shift_q      <= shift_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      word_ready_q <= word_ready_d;
      chain_rst_q  <= chain_rst_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign word_ready_o = word_ready_q;
  assign chain_rst_o  = chain_rst_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: small-config scenario loads against a timeline model, plus a default-size smoke load.
module tb_cfg_bitstream_loader;

  localparam int NT = 2, MC = 8, WW = 4, RC = 2;
  localparam int TOT = NT * MC, NWD = TOT / WW, P = RC + NT;
  localparam int BNW = 1152, BTOT = 36864;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, word_valid;
  logic [WW-1:0] word_in;
  logic          word_ready, chain_rst, data_out, data_valid, busy, done, error;

  logic          b_start, b_valid;
  logic [31:0]   b_word;
  logic          b_ready, b_chain_rst, b_dout, b_dv, b_busy, b_done, b_error;

  cfg_bitstream_loader #(.num_of_tiles(NT), .mem_cycles(MC), .word_width(WW), .rst_cycles(RC)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .word_in_i(word_in), .word_valid_i(word_valid),
    .word_ready_o(word_ready), .chain_rst_o(chain_rst), .data_out_o(data_out),
    .data_valid_o(data_valid), .busy_o(busy), .done_o(done), .error_o(error));

  cfg_bitstream_loader u_big (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .word_in_i(b_word), .word_valid_i(b_valid),
    .word_ready_o(b_ready), .chain_rst_o(b_chain_rst), .data_out_o(b_dout),
    .data_valid_o(b_dv), .busy_o(b_busy), .done_o(b_done), .error_o(b_error));

  int n_cmp = 0, n_err = 0;
  logic [WW-1:0] wq [8];
  logic [31:0]   bw [BNW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " chain_rst"}, chain_rst, 1);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " data_valid"}, data_valid, 0);
    chk({tag, " word_ready"}, word_ready, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " error"}, error, 0);
  endtask

  // mode 0: valid whenever words remain; 1: valid one cycle after ready seen; 2: random valid + stray starts
  task automatic run_load(input string name, input int mode, input int supply, input int rst_after);
    int acc, kdl, e_edge, nbits, lastbusy, idx;
    bit err, prev_rdy, prev_hs, v, want, finished;
    logic e_cr, e_dv, e_do, e_busy, e_done, e_err, e_rdy;
    acc = 0; kdl = 0; e_edge = 0; nbits = 0; err = 0; prev_rdy = 0; prev_hs = 0; finished = 0;
    @(negedge clk);
    start = 1'b1; word_valid = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      // word k is due on the edge that ends bit k*WW-1 (or the last preamble cycle for k=0)
      if (!err && kdl < NWD && c - 1 == P + kdl * WW) begin
        if (acc < kdl + 1) begin err = 1; e_edge = c - 1; end
        else kdl++;
      end
      lastbusy = err ? e_edge : P + TOT;
      e_busy = (c <= lastbusy);
      e_cr   = (c <= RC) || (c > lastbusy);
      e_dv   = (c > P) && (c <= lastbusy);
      idx    = c - P - 1;
      e_do   = e_dv ? wq[idx / WW][WW - 1 - idx % WW] : 1'b0;
      e_done = !err && (c == P + TOT + 1);
      e_err  = err && (c > e_edge);
      e_rdy  = !err && (c > RC) && (c <= P + TOT) && (acc == kdl) && (acc < NWD);
      chk($sformatf("%s c%0d chain_rst", name, c), chain_rst, e_cr);
      chk($sformatf("%s c%0d data_valid", name, c), data_valid, e_dv);
      chk($sformatf("%s c%0d data_out", name, c), data_out, e_do);
      chk($sformatf("%s c%0d busy", name, c), busy, e_busy);
      chk($sformatf("%s c%0d done", name, c), done, e_done);
      chk($sformatf("%s c%0d error", name, c), error, e_err);
      chk($sformatf("%s c%0d word_ready", name, c), word_ready, e_rdy);
      if (e_dv) nbits++;
      if (c == (err ? e_edge + 2 : P + TOT + 2)) begin finished = 1; break; end
      if (rst_after > 0 && nbits == rst_after) begin
        rst = 1'b1; word_valid = 1'b0;
        @(negedge clk);
        chk_reset_outs({name, " in-reset"});
        rst = 1'b0;
        @(negedge clk);
        chk({name, " after-reset done"}, done, 0);
        chk({name, " after-reset chain_rst"}, chain_rst, 1);
        chk({name, " after-reset busy"}, busy, 0);
        return;
      end
      want = (acc < supply);
      case (mode)
        0:       v = want;
        1:       v = want && prev_rdy && !prev_hs;
        default: v = want && ($urandom_range(0, 3) != 0);
      endcase
      word_valid = v;
      word_in    = want ? wq[acc] : WW'($urandom);
      if (mode == 2 && !err && c <= P + TOT) start = ($urandom_range(0, 3) == 0);
      prev_rdy = word_ready;
      prev_hs  = v && word_ready;
      if (prev_hs) acc++;
    end
    word_valid = 1'b0;
    chk({name, " finished in budget"}, finished, 1);
    chk({name, " handshakes"}, acc, err ? kdl : NWD);
  endtask

  task automatic set_nominal();
    wq[0] = 4'hA; wq[1] = 4'h5; wq[2] = 4'hF; wq[3] = 4'h0; wq[4] = 4'h3;
  endtask

  initial begin
    int b_acc, b_bits, b_fall, b_first, b_gap, b_done_cnt, b_bad, post;
    bit last_dv, prev_cr, want_bit;
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    b_start = 1'b0; b_valid = 1'b0; b_word = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    set_nominal();
    run_load("nominal", 0, 5, 0);
    run_load("late", 0, 0, 0);
    run_load("underrun", 0, 2, 0);
    run_load("recover", 0, 4, 0);
    run_load("throttle", 1, 4, 0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) wq[k] = WW'($urandom);
      run_load($sformatf("rand%0d", r), 2, 4, 0);
    end
    set_nominal();
    run_load("midrst", 0, 4, 5);
    run_load("post-rst", 0, 4, 0);

    for (int k = 0; k < BNW; k++) bw[k] = $urandom;
    b_acc = 0; b_bits = 0; b_fall = -1; b_first = -1; b_gap = 0; b_done_cnt = 0; b_bad = 0;
    post = 0; last_dv = 0; prev_cr = 1;
    @(negedge clk);
    b_start = 1'b1;
    for (int c = 1; c < 40000; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (prev_cr && !b_chain_rst && b_fall < 0) b_fall = c;
      prev_cr = b_chain_rst;
      if (b_dv) begin
        if (b_first < 0) b_first = c;
        else if (!last_dv) b_gap++;
        if (b_bits < BTOT) begin
          want_bit = bw[b_bits / 32][31 - b_bits % 32];
          if (b_dout !== want_bit) b_bad++;
        end
        b_bits++;
      end
      last_dv = b_dv;
      if (b_done) b_done_cnt++;
      if (b_done_cnt > 0) post++;
      if (post == 3) break;
      b_valid = (b_acc < BNW);
      b_word  = (b_acc < BNW) ? bw[b_acc] : 32'h0;
      if (b_valid && b_ready) b_acc++;
    end
    b_valid = 1'b0;
    chk("big bits", b_bits, BTOT);
    chk("big preamble", b_first - b_fall, 9);
    chk("big bit errors", b_bad, 0);
    chk("big gaps", b_gap, 0);
    chk("big done count", b_done_cnt, 1);
    chk("big handshakes", b_acc, BNW);
    chk("big error", b_error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
